trigger_capture_buf: RTL and testbench
======================================

Name: trigger_capture_buf

Overview:
- Parametrised successor to the single-channel frame-synchronised capture copy.
- Captures CH channels of streaming ADC samples into a ring buffer, with pre-trigger history and a selectable trigger edge on one channel.
- Publishes the finished record to the display path by a ping-pong bank swap, taken only inside the VGA sync window.
- Sits between the ADC sample stream and the waveform renderer; the renderer reads samples by channel and index.

Parameters:
- DATA_W, 12, sample and trigger-level width.
- DEPTH, 512, samples per channel per record; power of two, at least 4.
- CH, 2, channel count, at least 1.
- PRE_DEPTH, 128, pre-trigger samples per record; 1 to DEPTH-1.
- SWAP_HCOUNT, 600, hcount value that opens the swap window.
- SWAP_VLIMIT, 3, vcount values below this also open the swap window.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset; 0 = reset, sampled on posedge clk.
- in  vga_if.in  -  timing bundle; only hcount and vcount are used.
- arm  input  1  one-cycle request to start a capture.
- trig_mode  input  2  00 rising, 01 falling, 10 either edge, 11 force.
- trig_ch  input  max(1,$clog2(CH))  trigger source channel.
- trig_level  input  DATA_W  unsigned trigger threshold.
- sample_valid  input  1  sample qualifier.
- sample  input  CH x DATA_W  unpacked array, one sample per channel.
- ready  output  1  high in IDLE; capture may be armed.
- armed  output  1  high in PRE, WAIT_TRIG and POST.
- trig_pulse  output  1  one-cycle pulse on the accepted trigger sample.
- swap_pulse  output  1  one-cycle pulse when the new record becomes visible.
- rd_ch  input  max(1,$clog2(CH))  display read channel.
- rd_addr  input  $clog2(DEPTH)  display read index; 0 = oldest (pre-trigger) sample.
- rd_data  output  DATA_W  registered read data.

Behaviour:
- Reset (rst=0): state IDLE; ready=1; armed=0; trig_pulse=0; swap_pulse=0; rd_data=0; front bank=0; front_start=0; prev_valid=0.
- Sample memories are not reset. Reading before the first swap returns undefined data; a bench must treat it as don't-care.
- Storage: two banks, each CH x DEPTH words. Capture always writes the back bank, which is the bank not selected as front.
- State IDLE:
  - arm=1 → PRE, next cycle.
  - In the same transition: wr_ptr=0, cnt=0, prev_valid=0.
- All capture states: each sample_valid=1 cycle writes sample[c] to back[c][wr_ptr] for every channel c, then increments wr_ptr modulo DEPTH (natural wrap).
- State PRE: count PRE_DEPTH valid samples, then → WAIT_TRIG. Triggers are not evaluated in PRE.
- prev tracking: on every valid sample in PRE, WAIT_TRIG and POST, prev ← sample[trig_ch] and prev_valid ← 1.
- State WAIT_TRIG: keeps overwriting the ring. A valid sample is a trigger when:
  - rising: prev_valid && prev < trig_level && cur >= trig_level.
  - falling: prev_valid && prev >= trig_level && cur < trig_level.
  - either: rising or falling.
  - force: any valid sample.
  - All comparisons unsigned, DATA_W bits.
- On trigger:
  - The sample is written normally.
  - trig_pulse=1 for that cycle.
  - start_ptr ← (wr_ptr − PRE_DEPTH) mod DEPTH, where wr_ptr is the address of the trigger sample.
  - → POST.
- State POST: accept DEPTH−PRE_DEPTH−1 further valid samples, then → DONE. In DONE, ready=0 and armed=0.
- State DONE: in any cycle where (in.hcount==SWAP_HCOUNT || in.vcount<SWAP_VLIMIT):
  - front bank toggles; front_start ← start_ptr; swap_pulse=1; → IDLE.
  - The window is evaluated only while in DONE, so the swap happens no earlier than the cycle after entering DONE.
- Read path: rd_data ← front[rd_ch][(rd_addr + front_start) mod DEPTH].
  - Latency 1 cycle.
  - Uses the front bank and front_start registered before the edge, so a read launched in the swap cycle returns old-record data.
- arm while not IDLE: ignored. sample_valid in IDLE or DONE: ignored, no write, prev unchanged.
- Changing trig_mode, trig_ch or trig_level mid-capture: takes effect on the next evaluated sample.
- trig_ch ≥ CH: treated as channel 0.
- Reset mid-capture: aborts the capture; the front bank reverts to bank 0 and memory contents are untouched.

Test Plan:
- Reset, then arm with CH=2, DEPTH=512, PRE=128, rising, level 2048; ch0 ramps 0..4095 step 16, sample_valid=1 → trig_pulse on the sample value 2048. After the swap window, rd_addr 128 on ch0 returns 2048 (1-cycle latency) and rd_addr 0 returns 0.
- Falling mode with ch1 descending across level 1000, trig_ch=1 → trigger on the first ch1 sample <1000. Ch0 data stored at the same indices.
- Force mode, sample_valid toggling every other cycle → trigger on the first valid sample in WAIT_TRIG. Exactly 512 writes per record; ready rises only after swap_pulse.
- Capture completes with hcount=100, vcount=200 → stays in DONE, old data still read. swap_pulse occurs exactly in the cycle hcount==600; a read issued that cycle returns old data and the next cycle returns new data.
- Ring wrap: hold a no-trigger level for 1000 samples, then trigger → start_ptr wraps and rd_addr 0..511 returns a contiguous record.
- Assert rst=0 in POST → next cycle ready=1, armed=0; arm pulses during PRE, WAIT_TRIG and POST are ignored.

Source files
------------

// File: rtl/trigger_capture_buf_if.sv
// VGA timing bundle shared by the display path; the capture buffer only
// looks at the pixel and line counters.
interface vga_if;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    modport in (input hcount, input vcount);
endinterface

// File: rtl/trigger_capture_buf.sv
// Multi-channel triggered capture into a ring buffer with pre-trigger history;
// finished records are published to the renderer by a ping-pong bank swap.
module trigger_capture_buf #(
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 512,
    parameter int CH          = 2,
    parameter int PRE_DEPTH   = 128,
    parameter int SWAP_HCOUNT = 600,
    parameter int SWAP_VLIMIT = 3,
    localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 in,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [CH_W-1:0]   trig_ch,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample [CH],
    output logic              ready,
    output logic              armed,
    output logic              trig_pulse,
    output logic              swap_pulse,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    localparam int            POST_LEN  = DEPTH - PRE_DEPTH - 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_LEN - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEPTH);
    localparam logic [10:0]   SWAP_H    = 11'(SWAP_HCOUNT);
    localparam logic [9:0]    SWAP_V    = 10'(SWAP_VLIMIT);

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       start_q, start_d;
    logic [AW-1:0]       front_start_q, front_start_d;
    logic                front_q, front_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic [DATA_W-1:0]   mem [2][CH][DEPTH];

    logic [CH_W-1:0]     tsel;
    logic [CH_W-1:0]     rsel;
    logic [DATA_W-1:0]   cur;
    logic [AW-1:0]       rd_idx;
    logic                capturing;
    logic                we;
    logic                rise;
    logic                fall;
    logic                trig_hit;
    logic                swap_hit;
    logic                swap_window;

    // Out-of-range channel selects fall back to channel 0.
    assign tsel        = (32'(trig_ch) < CH) ? trig_ch : '0;
    assign rsel        = (32'(rd_ch) < CH) ? rd_ch : '0;
    assign cur         = sample[tsel];
    assign rd_idx      = rd_addr + front_start_q;
    assign capturing   = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign rise        = prev_valid_q && (prev_q < trig_level) && (cur >= trig_level);
    assign fall        = prev_valid_q && (prev_q >= trig_level) && (cur < trig_level);
    assign swap_window = (in.hcount == SWAP_H) || (in.vcount < SWAP_V);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        start_d       = start_q;
        front_d       = front_q;
        front_start_d = front_start_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        we            = 1'b0;
        trig_hit      = 1'b0;
        swap_hit      = 1'b0;

        if (capturing && sample_valid) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            prev_d       = cur;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d      = S_PRE;
                    wr_ptr_d     = '0;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                end
            end
            S_PRE: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_WAIT_TRIG;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_TRIG: begin
                if (sample_valid) begin
                    case (trig_mode)
                        2'b00:   trig_hit = rise;
                        2'b01:   trig_hit = fall;
                        2'b10:   trig_hit = rise || fall;
                        default: trig_hit = 1'b1;
                    endcase
                    if (trig_hit) begin
                        // Oldest kept sample sits PRE_DEPTH slots behind the trigger.
                        start_d = wr_ptr_q - PRE_OFS;
                        cnt_d   = '0;
                        state_d = (POST_LEN == 0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == POST_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (swap_window) begin
                    swap_hit      = 1'b1;
                    front_d       = ~front_q;
                    front_start_d = start_q;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            start_q       <= '0;
            front_q       <= 1'b0;
            front_start_q <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            front_q       <= front_d;
            front_start_q <= front_start_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
        end
    end

    // NOTE: sample storage has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we && rst) begin
            for (int c = 0; c < CH; c++) begin
                mem[~front_q][c][wr_ptr_q] <= sample[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[front_q][rsel][rd_idx];
        end
    end

    assign rd_data    = rd_data_q;
    assign ready      = (state_q == S_IDLE);
    assign armed      = capturing;
    assign trig_pulse = rst && trig_hit;
    assign swap_pulse = rst && swap_hit;

endmodule

// File: tb/tb_trigger_capture_buf.sv
// Directed bench for trigger_capture_buf: a record-level model predicts every
// output each cycle, and hand-computed literals pin the model.
module tb_trigger_capture_buf;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 512;
    localparam int CH     = 2;
    localparam int PRE    = 128;
    localparam int SEQ_N  = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic [1:0]        trig_mode;
    logic [0:0]        trig_ch;
    logic [DATA_W-1:0] trig_level;
    logic              sample_valid;
    logic [DATA_W-1:0] sample [CH];
    logic              ready;
    logic              armed;
    logic              trig_pulse;
    logic              swap_pulse;
    logic [0:0]        rd_ch;
    logic [8:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;

    vga_if vga ();

    always #5 clk = ~clk;

    trigger_capture_buf #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CH(CH), .PRE_DEPTH(PRE),
        .SWAP_HCOUNT(600), .SWAP_VLIMIT(3)
    ) dut (
        .clk(clk), .rst(rst), .in(vga), .arm(arm), .trig_mode(trig_mode),
        .trig_ch(trig_ch), .trig_level(trig_level), .sample_valid(sample_valid),
        .sample(sample), .ready(ready), .armed(armed), .trig_pulse(trig_pulse),
        .swap_pulse(swap_pulse), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record-level model: the sequence of accepted samples since arm, the index
    // of the trigger within it, and the record currently shown to the renderer.
    bit                m_init = 0, m_busy = 0, m_done = 0, m_prev_ok = 0;
    bit                m_front_ok = 0, m_rd_ok = 0;
    int                m_nw = 0, m_trig_at = -1, m_swaps = 0;
    logic [DATA_W-1:0] m_prev, m_rd;
    logic [DATA_W-1:0] m_seq   [CH][SEQ_N];
    logic [DATA_W-1:0] m_front [CH][DEPTH];

    always @(negedge clk) begin : compare
        bit                t_exp, s_exp;
        int                tsel;
        logic [DATA_W-1:0] cur;
        if (m_init) begin
            check("ready", ready, !m_busy && !m_done);
            check("armed", armed, m_busy);
        end
        tsel = (int'(trig_ch) < CH) ? int'(trig_ch) : 0;
        cur  = sample[tsel];
        t_exp = 0;
        if (m_init && rst && m_busy && sample_valid && m_trig_at < 0 && m_nw >= PRE) begin
            case (trig_mode)
                2'b00: t_exp = m_prev_ok && m_prev < trig_level && cur >= trig_level;
                2'b01: t_exp = m_prev_ok && m_prev >= trig_level && cur < trig_level;
                2'b10: t_exp = m_prev_ok && ((m_prev < trig_level) != (cur < trig_level));
                default: t_exp = 1;
            endcase
        end
        s_exp = m_init && rst && m_done && (vga.hcount == 11'd600 || vga.vcount < 10'd3);
        if (m_init) begin
            check("trig_pulse", trig_pulse, t_exp);
            check("swap_pulse", swap_pulse, s_exp);
            if (m_rd_ok) check("rd_data", rd_data, m_rd);
        end
        // The read launched this cycle sees the record shown before the edge.
        if (!rst) begin
            m_rd = '0; m_rd_ok = 1;
        end else begin
            m_rd_ok = m_front_ok;
            if (m_front_ok) m_rd = m_front[rd_ch][rd_addr];
        end
        if (!rst) begin
            m_init = 1; m_busy = 0; m_done = 0; m_prev_ok = 0; m_front_ok = 0;
        end else if (m_init) begin
            if (m_busy && sample_valid) begin
                if (m_nw < SEQ_N) for (int c = 0; c < CH; c++) m_seq[c][m_nw] = sample[c];
                if (t_exp) m_trig_at = m_nw;
                m_nw++;
                m_prev = cur; m_prev_ok = 1;
                if (m_trig_at >= 0 && m_nw == m_trig_at + DEPTH - PRE) begin
                    m_busy = 0; m_done = 1;
                end
            end else if (s_exp) begin
                for (int c = 0; c < CH; c++)
                    for (int i = 0; i < DEPTH; i++) m_front[c][i] = m_seq[c][m_trig_at - PRE + i];
                m_front_ok = 1; m_done = 0; m_swaps++;
            end else if (!m_busy && !m_done && arm) begin
                m_busy = 1; m_nw = 0; m_trig_at = -1; m_prev_ok = 0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] gen(input int tid, input int v, input int c);
        int x;
        case (tid)
            1: x = (c == 0) ? (v * 16) % 4096 : 4095 - (v * 16) % 4096;
            2: x = (c == 0) ? v : ((2000 - 5 * v) > 0 ? 2000 - 5 * v : 0);
            3: x = (c == 0) ? 3000 + v : v;
            4: x = (c == 0) ? (v < 130 ? 100 : 700 + v) : v;
            5: x = (c == 0) ? (v < 1000 ? 100 : 3000) : v;
            default: x = (c == 0) ? (v < 140 ? 10 : 900) : v;
        endcase
        return DATA_W'(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int dut_trig_v;
    int dut_writes;

    // Arms once, then streams samples until the record is done (or swapped),
    // or, for test 6, until reset is asserted in POST.
    task automatic run_capture(input int tid, input bit stop_on_done, input int budget);
        int v = 0;
        int sw0 = m_swaps;
        bit ok = 0;
        dut_trig_v = -1;
        dut_writes = 0;
        arm = 1; sample_valid = 0;
        tick();
        arm = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            sample_valid = (tid == 3) ? (cyc % 2 == 0) : 1'b1;
            for (int c = 0; c < CH; c++) sample[c] = gen(tid, v, c);
            arm = (tid == 6) && (v == 50 || v == 135 || v == 200);
            if (tid == 6 && v == 250) rst = 0;
            #2;
            if (trig_pulse) dut_trig_v = v;
            if (sample_valid && armed) dut_writes++;
            tick();
            if (sample_valid) v++;
            if (tid == 6 && !rst) begin ok = 1; break; end
            if (stop_on_done ? m_done : (m_swaps != sw0)) begin ok = 1; break; end
        end
        sample_valid = 0; arm = 0;
        check($sformatf("t%0d_completes", tid), ok, 1'b1);
    endtask

    task automatic lit_read(input int ch, input int addr, input int exp, input string name);
        rd_ch = ch[0:0]; rd_addr = addr[8:0];
        tick();
        check(name, rd_data, exp);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 0; arm = 0; trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd2048;
        sample_valid = 0; rd_ch = 0; rd_addr = 0;
        for (int c = 0; c < CH; c++) sample[c] = '0;
        vga.hcount = 11'd0; vga.vcount = 10'd0;
        repeat (3) tick();
        check("rst_ready", ready, 1'b1);
        check("rst_armed", armed, 1'b0);
        check("rst_rd_data", rd_data, 0);
        check("rst_trig", trig_pulse, 1'b0);
        check("rst_swap", swap_pulse, 1'b0);
        rst = 1;
        tick();

        // 1: rising on ch0 ramp, level 2048.
        trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd2048;
        run_capture(1, 0, 2000);
        check("t1_trig_sample", dut_trig_v, 128);
        check("t1_model_trig", m_trig_at, 128);
        check("t1_writes", dut_writes, 512);
        lit_read(0, 128, 2048, "t1_rd128");
        lit_read(0, 0, 0, "t1_rd0");

        // 2: falling on ch1 descending through 1000.
        trig_mode = 2'b01; trig_ch = 1; trig_level = 12'd1000;
        run_capture(2, 0, 2000);
        check("t2_trig_sample", dut_trig_v, 201);
        lit_read(1, 128, 995, "t2_rd128_ch1");
        lit_read(0, 128, 201, "t2_rd128_ch0");
        lit_read(1, 0, 1635, "t2_rd0_ch1");
        lit_read(0, 0, 73, "t2_rd0_ch0");

        // 3: force mode, valid every other cycle.
        trig_mode = 2'b11; trig_ch = 0;
        run_capture(3, 0, 3000);
        check("t3_trig_sample", dut_trig_v, 128);
        check("t3_writes", dut_writes, 512);
        lit_read(0, 0, 3000, "t3_rd0");
        lit_read(0, 511, 3511, "t3_rd511");
        lit_read(1, 128, 128, "t3_rd128_ch1");

        // 4: swap held off until hcount reaches 600.
        vga.hcount = 11'd100; vga.vcount = 10'd200;
        trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd500;
        run_capture(4, 1, 2000);
        check("t4_trig_sample", dut_trig_v, 130);
        rd_ch = 0; rd_addr = 0;
        repeat (5) tick();
        check("t4_hold_ready", ready, 1'b0);
        check("t4_old_rd", rd_data, 3000);
        vga.hcount = 11'd600;
        #1;
        check("t4_swap_pulse", swap_pulse, 1'b1);
        tick();
        check("t4_swap_cycle_rd", rd_data, 3000);
        vga.hcount = 11'd601;
        tick();
        check("t4_new_rd", rd_data, 100);
        check("t4_ready_after", ready, 1'b1);

        // 5: long no-trigger stretch wraps the ring before the trigger.
        vga.hcount = 11'd0; vga.vcount = 10'd0;
        trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd2000;
        run_capture(5, 0, 3000);
        check("t5_trig_sample", dut_trig_v, 1000);
        for (int i = 0; i < DEPTH; i++) begin
            rd_ch = 1; rd_addr = i[8:0];
            tick();
        end
        lit_read(1, 0, 872, "t5_rd0_ch1");
        lit_read(1, 511, 1383, "t5_rd511_ch1");
        lit_read(0, 127, 100, "t5_rd127_ch0");
        lit_read(0, 128, 3000, "t5_rd128_ch0");

        // 6: stray arms ignored, then reset in POST aborts.
        trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd500;
        run_capture(6, 0, 2000);
        check("t6_trig_sample", dut_trig_v, 140);
        check("t6_ready_after_rst", ready, 1'b1);
        check("t6_armed_after_rst", armed, 1'b0);
        check("t6_rd_after_rst", rd_data, 0);
        rst = 1;
        tick();

        // Full capture after the abort.
        trig_mode = 2'b00; trig_ch = 0; trig_level = 12'd2048;
        run_capture(1, 0, 2000);
        check("t7_trig_sample", dut_trig_v, 128);
        lit_read(0, 128, 2048, "t7_rd128");
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
